// File: rtl/cr16_mc_datapath.sv
// cr16_mc_datapath: multicycle CR16 baseline core with register file, ALU,
// shifter, flag register, PC and a single request/ready memory port.
module cr16_mc_datapath #(
   parameter int unsigned      WIDTH    = 16,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ready,
   output logic [4:0]       flags,
   output logic [WIDTH-1:0] pc,
   input  logic [3:0]       dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   localparam int unsigned      MSB  = WIDTH - 1;
   localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);
   // flag bit positions within {C,L,F,Z,N}
   localparam int unsigned F_C = 4;
   localparam int unsigned F_L = 3;
   localparam int unsigned F_F = 2;
   localparam int unsigned F_Z = 1;
   localparam int unsigned F_N = 0;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

   state_t           state_q;
   logic [15:0]      ir_q;
   logic [WIDTH-1:0] pc_q;
   logic [4:0]       flags_q;
   logic [WIDTH-1:0] opa_q;   // R[rd]
   logic [WIDTH-1:0] opb_q;   // R[rs]
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] regs_q [16];

   logic [3:0]       op, rd, ext, rs;
   logic [WIDTH-1:0] imm_sx, sh5_sx;
   logic             alu_imm, alu_ok;
   logic [3:0]       alu_sel;
   logic [WIDTH-1:0] alu_src;
   logic [WIDTH:0]   add_w, sub_w;
   logic             add_ovf, sub_ovf, slt;

   logic [WIDTH-1:0] ex_res, ex_pc;
   logic [4:0]       ex_flags;
   state_t           ex_next;

   assign op      = ir_q[15:12];
   assign rd      = ir_q[11:8];
   assign ext     = ir_q[7:4];
   assign rs      = ir_q[3:0];
   assign imm_sx  = {{(WIDTH-8){ir_q[7]}}, ir_q[7:0]};
   assign sh5_sx  = {{(WIDTH-5){ext[0]}}, ext[0], rs};

   // Immediate forms reuse the register-form ALU encoding held in op.
   assign alu_imm = (op == 4'b0101) || (op == 4'b1001) || (op == 4'b1011) || (op == 4'b1101);
   assign alu_ok  = alu_imm || (op == 4'b0000);
   assign alu_sel = alu_imm ? op : ext;
   assign alu_src = alu_imm ? imm_sx : opb_q;
   assign add_w   = {1'b0, opa_q} + {1'b0, alu_src};
   assign sub_w   = {1'b0, opa_q} - {1'b0, alu_src};
   assign add_ovf = (opa_q[MSB] == alu_src[MSB]) && (add_w[MSB] != opa_q[MSB]);
   assign sub_ovf = (opa_q[MSB] != alu_src[MSB]) && (sub_w[MSB] != opa_q[MSB]);
   assign slt     = $signed(opa_q) < $signed(alu_src);

   assign flags    = flags_q;
   assign pc       = pc_q;
   assign dbg_data = regs_q[dbg_addr];

   // Signed shift amount: positive shifts left, negative shifts right logically.
   function automatic logic [WIDTH-1:0] lsh(input logic [WIDTH-1:0] val,
                                            input logic [WIDTH-1:0] amt);
      logic [WIDTH-1:0] mag;
      if (amt[WIDTH-1]) begin
         mag = -amt;
         lsh = (mag >= WLIM) ? '0 : (val >> mag);
      end else begin
         lsh = (amt >= WLIM) ? '0 : (val << amt);
      end
   endfunction

   // Execute-stage result, flags, next PC and next state.
   always_comb begin
      ex_res   = opa_q;
      ex_flags = flags_q;
      ex_next  = S_FETCH;
      ex_pc    = pc_q + WIDTH'(1);
      if (alu_ok) begin
         ex_next = S_WB;
         case (alu_sel)
            4'b0101: begin
               ex_res        = add_w[WIDTH-1:0];
               ex_flags[F_C] = add_w[WIDTH];
               ex_flags[F_F] = add_ovf;
            end
            4'b1001: begin
               ex_res        = sub_w[WIDTH-1:0];
               ex_flags[F_C] = sub_w[WIDTH];
               ex_flags[F_F] = sub_ovf;
            end
            4'b1011: begin
               ex_flags[F_Z] = (opa_q == alu_src);
               ex_flags[F_L] = sub_w[WIDTH];
               ex_flags[F_N] = slt;
            end
            4'b0001: ex_res = opa_q & alu_src;
            4'b0010: ex_res = opa_q | alu_src;
            4'b0011: ex_res = opa_q ^ alu_src;
            4'b1101: ex_res = alu_src;
            default: ex_next = S_FETCH;
         endcase
      end else begin
         case (op)
            4'b1000: begin
               if (ext == 4'b0100) begin
                  ex_res  = lsh(opa_q, opb_q);
                  ex_next = S_WB;
               end else if (ext[3:1] == 3'b000) begin
                  ex_res  = lsh(opa_q, sh5_sx);
                  ex_next = S_WB;
               end
            end
            4'b0100: begin
               if ((ext == 4'b0000) || (ext == 4'b0100)) ex_next = S_MEM;
            end
            4'b1100: begin
               if (((rd == 4'b0000) && flags_q[F_Z]) ||
                   ((rd == 4'b0001) && !flags_q[F_Z]) ||
                   (rd == 4'b1110))
                  ex_pc = pc_q + imm_sx;
            end
            default: ;
         endcase
      end
   end

   // Memory port; gated by reset so a pending store is dropped immediately.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = pc_q;
      mem_wdata = '0;
      if (!reset) begin
         if (state_q == S_FETCH) begin
            mem_req = 1'b1;
         end else if (state_q == S_MEM) begin
            mem_req  = 1'b1;
            mem_addr = opb_q;
            if (ext == 4'b0100) begin
               mem_we    = 1'b1;
               mem_wdata = opa_q;
            end
         end
      end
   end

   // Sequencer and architectural state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         flags_q <= '0;
         ir_q    <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (mem_ready) begin
                  ir_q    <= mem_rdata[15:0];
                  state_q <= S_DECODE;
               end
            end
            S_DECODE: begin
               opa_q   <= regs_q[rd];
               opb_q   <= regs_q[rs];
               state_q <= S_EXEC;
            end
            S_EXEC: begin
               res_q   <= ex_res;
               flags_q <= ex_flags;
               pc_q    <= ex_pc;
               state_q <= ex_next;
            end
            S_MEM: begin
               if (mem_ready) begin
                  res_q   <= mem_rdata;
                  state_q <= (ext == 4'b0100) ? S_FETCH : S_WB;
               end
            end
            S_WB: begin
               regs_q[rd] <= res_q;
               state_q    <= S_FETCH;
            end
            default: state_q <= S_FETCH;
         endcase
      end
   end

endmodule

// File: doc/cr16_mc_datapath.md
# cr16_mc_datapath

Parametrised multicycle CPU core that merges the existing register/ALU/shifter datapath with its own fetch-decode-execute sequencer, flag register and program counter into one self-contained block. It runs the 16-bit baseline instruction set at a configurable data width. Instructions and data come through a single ready/request memory port, and a debug read port exposes the register file to the bench. It sits between the unified memory arbiter and the top-level system.

## Interface
- WIDTH, 16: data/register/address width; must be >= 16.
- RESET_PC, 0: PC value loaded on reset.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  memory access request; held until mem_ready.
- mem_we  out  1  write strobe, valid with mem_req.
- mem_addr  out  WIDTH  word address.
- mem_wdata  out  WIDTH  store data.
- mem_rdata  in  WIDTH  read data, valid in the cycle mem_ready=1; instructions are mem_rdata[15:0].
- mem_ready  in  1  access completes this cycle.
- flags  out  5  {C,L,F,Z,N}.
- pc  out  WIDTH  current PC.
- dbg_addr  in  4  register index for debug read.
- dbg_data  out  WIDTH  combinational read of R[dbg_addr].

## Operation
- The instruction fields are: op[15:12], rd[11:8], ext[7:4], rs[3:0], imm8[7:0]. The 16 registers are all writable. sext() extends imm8 to WIDTH bits.
- The FSM has five states: FETCH, DECODE, EXECUTE, MEM, WB.
  - FETCH drives mem_req=1, mem_we=0 and mem_addr=pc. It waits for mem_ready, latches the instruction, then moves to DECODE.
  - DECODE latches the R[rs] and R[rd] operands, then moves to EXECUTE.
  - EXECUTE computes the result and updates flags. Non-branch instructions set pc <= pc+1. Loads and stores go to MEM, branches and NOPs go to FETCH, and everything else goes to WB.
  - MEM drives mem_req=1 and mem_addr=R[rs]. A store additionally drives mem_we=1 and mem_wdata=R[rd]. MEM waits for mem_ready; a load then goes to WB, a store goes to FETCH.
  - WB writes the result or the load data to R[rd], then moves to FETCH.
- Register-register instructions (op=0000, ext selects the operation):
  - ADD (0101), SUB (1001, rd-rs), CMP (1011), AND (0001), OR (0010), XOR (0011), MOV (1101).
- Immediate instructions, using sext(imm8) as the operand:
  - ADDI (0101), SUBI (1001), CMPI (1011), MOVI (1101).
- Shifts (op=1000):
  - LSH (ext=0100): shift amount is R[rs] taken as signed.
  - LSHI (ext=000x): shift amount is the signed 5-bit value {ext[0],rs}.
  - A positive amount shifts left; a negative amount is a logical right shift. Magnitudes >= WIDTH yield 0.
- Memory (op=0100): LOAD (ext=0000) reads into rd, STOR (ext=0100) writes R[rd].
- Bcond (op=1100), condition in rd:
  - 0000 EQ (Z=1), 0001 NE (Z=0), 1110 always.
  - Taken: pc <= pc + sext(imm8). Not taken: pc <= pc+1.
- Flags:
  - ADD/ADDI set C (unsigned carry) and F (signed overflow).
  - SUB/SUBI set C (borrow) and F.
  - CMP/CMPI set Z (rd==src), L (rd<src unsigned) and N (rd<src signed).
  - All other instructions leave flags unchanged.
- All arithmetic is modulo 2^WIDTH.
- Any undefined encoding executes as a NOP (FETCH, DECODE, EXECUTE, pc+1, no write).

## Timing
- Reset values: state=FETCH, pc=RESET_PC, all registers 0, flags 0. While reset is high, mem_req=0, mem_we=0 and mem_wdata=0.
- The first fetch request appears in the first cycle after reset deasserts.
- Cycle counts with mem_ready tied high:
  - ALU ops and shifts: 4 cycles.
  - LOAD: 5 cycles.
  - STOR: 4 cycles.
  - Branch and NOP: 3 cycles.
- Each cycle mem_ready is low adds one cycle. mem_addr, mem_we and mem_wdata stay stable while mem_req=1.
- A register write from WB is visible on dbg_data in the cycle after WB.
- Reset mid-instruction abandons the instruction: no register, flag or memory write occurs in or after the reset cycle.
- The PC wraps modulo 2^WIDTH.

## Test plan
- Reset then MOVI R1,#5; ADDI R1,#-7 -> R1 = 0xFFFE (WIDTH=16), C=0, F=0, pc=2 after 8 cycles.
- CMP R2=3 vs R3=0xFFFF -> Z=0, L=1 (unsigned), N=0 (signed); then BEQ #4 is not taken (pc+1), and after CMP equal values BEQ #-2 sets pc = branch pc - 2.
- LSHI R4=0x0081 by +3 -> 0x0408; by -1 -> 0x0040; LSH by R = 16 -> 0.
- STOR R5=0xBEEF to [R6=0x20] with mem_ready low for 2 cycles -> single write with stable addr/data; LOAD back -> R7=0xBEEF in 7 cycles total.
- WIDTH=32: ADD 0xFFFFFFFF+1 -> 0, C=1; ADD 0x7FFFFFFF+1 -> F=1.
- Assert reset during MEM of a STOR -> mem_we drops the same cycle, pc=RESET_PC, all registers read 0 via dbg.
